// File: rtl/seq_divider_if.sv
// Request/response bundle for seq_divider: operand handshake in, results and status out.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signctl;
  logic             remainder_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] result;
  logic             dbz;

  modport master (
    output start, a, b, signctl, remainder_out,
    input  busy, done, q, r, result, dbz
  );

  modport slave (
    input  start, a, b, signctl, remainder_out,
    output busy, done, q, r, result, dbz
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, signed/unsigned with
// truncating quotient and dividend-signed remainder.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             rsel;
  logic             dz;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] res_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    a_mag   = (bus.signctl && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag   = (bus.signctl && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    // one extra bit so the compare against a divisor up to 2^WIDTH-1 cannot wrap
    rem_sh  = {rem, dvd[WIDTH-1]};
    rem_sub = rem_sh[WIDTH-1:0] - dsr;
    q_fix   = neg_q ? -dvd : dvd;
    r_fix   = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dvd    <= '0;
      dsr    <= '0;
      rem    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      rsel   <= 1'b0;
      dz     <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
      res_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rsel   <= bus.remainder_out;
            neg_q  <= bus.signctl & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r  <= bus.signctl & bus.a[WIDTH-1];
            dsr    <= b_mag;
            cnt    <= '0;
            busy_r <= 1'b1;
            if (bus.b == '0) begin
              // Qmag = all ones and Rmag = |a| make the sign fix-up yield the
              // defined divide-by-zero results (q = -1/+1/all-ones, r = a)
              dz    <= 1'b1;
              dvd   <= '1;
              rem   <= a_mag;
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              dvd   <= a_mag;
              rem   <= '0;
              state <= ITER;
            end
          end
        end
        ITER: begin
          if (rem_sh >= {1'b0, dsr}) begin
            rem <= rem_sub;
            dvd <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          q_r    <= q_fix;
          r_r    <= r_fix;
          res_r  <= rsel ? r_fix : q_fix;
          dbz_r  <= dz;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.q      = q_r;
  assign bus.r      = r_r;
  assign bus.result = res_r;
  assign bus.dbz    = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus handshake, back-to-back and reset-abort sequences.
module tb_seq_divider;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) dif ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(dif));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic        rsel;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Call at posedge+#1; returns at posedge+#1 just after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic rs);
    dif.a = a; dif.b = b; dif.signctl = s; dif.remainder_out = rs; dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
  endtask

  // Starts right after the accept edge; counts edges until done, bounded.
  task automatic wait_done(input string tag, input logic [31:0] hold_q, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    if (dif.busy) bcnt++;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (dif.done) break;
      if (dif.busy) bcnt++;
      if (lat == 5) chk({tag, " q hold mid-op"}, dif.q, hold_q);
    end
    chk({tag, " done seen"}, {31'b0, dif.done}, 32'd1);
    chk({tag, " busy low at done"}, {31'b0, dif.busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int bcnt;
    logic [31:0] prev_q;

    vecs[0]  = '{32'd100,      32'd7,        1'b0, 1'b0, 32'd14,       32'd2,        1'b0, 33};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 32'd0,        1'b0, 33};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0,        32'h80000000, 1'b0, 33};
    vecs[5]  = '{32'h12345678, 32'd0,        1'b0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1};
    vecs[6]  = '{32'hFFFFFFFB, 32'd0,        1'b1, 1'b1, 32'd1,        32'hFFFFFFFB, 1'b1, 1};
    vecs[7]  = '{32'd5,        32'd0,        1'b1, 1'b0, 32'hFFFFFFFF, 32'd5,        1'b1, 1};
    vecs[8]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 33};
    vecs[9]  = '{32'd3,        32'd10,       1'b0, 1'b1, 32'd0,        32'd3,        1'b0, 33};
    vecs[10] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 33};
    vecs[11] = '{32'hFFFFFFFF, 32'h00000010, 1'b0, 1'b1, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 33};

    dif.start = 1'b0; dif.a = '0; dif.b = '0; dif.signctl = 1'b0; dif.remainder_out = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy",   {31'b0, dif.busy}, 32'd0);
    chk("reset done",   {31'b0, dif.done}, 32'd0);
    chk("reset q",      dif.q, 32'd0);
    chk("reset r",      dif.r, 32'd0);
    chk("reset result", dif.result, 32'd0);
    chk("reset dbz",    {31'b0, dif.dbz}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    prev_q = 32'd0;
    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      issue(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].rsel);
      wait_done(tag, prev_q, lat, bcnt);
      chk({tag, " latency"}, lat, vecs[i].lat);
      chk({tag, " busy cycles"}, bcnt, vecs[i].lat);
      chk({tag, " q"}, dif.q, vecs[i].q);
      chk({tag, " r"}, dif.r, vecs[i].r);
      chk({tag, " result"}, dif.result, vecs[i].rsel ? vecs[i].r : vecs[i].q);
      chk({tag, " dbz"}, {31'b0, dif.dbz}, {31'b0, vecs[i].dbz});
      @(posedge clk); #1;
      chk({tag, " done one cycle"}, {31'b0, dif.done}, 32'd0);
      chk({tag, " q held"}, dif.q, vecs[i].q);
      prev_q = vecs[i].q;
    end

    // start held high with operands changing while busy: only the first pair counts
    dif.a = 32'd100; dif.b = 32'd7; dif.signctl = 1'b0; dif.remainder_out = 1'b0; dif.start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      dif.a = $urandom; dif.b = $urandom_range(1, 50);
      @(posedge clk); #1;
      lat++;
      if (dif.done) break;
    end
    dif.start = 1'b0;
    chk("held start latency", lat, 33);
    chk("held start q", dif.q, 32'd14);
    chk("held start r", dif.r, 32'd2);

    // back-to-back: new operands presented while done is high
    @(posedge clk); #1;
    issue(32'd1000, 32'd10, 1'b0, 1'b0);
    wait_done("b2b first", 32'd14, lat, bcnt);
    chk("b2b first q", dif.q, 32'd100);
    issue(32'd200, 32'd3, 1'b0, 1'b1);
    wait_done("b2b second", 32'd100, lat, bcnt);
    chk("b2b second latency", lat, 33);
    chk("b2b second q", dif.q, 32'd66);
    chk("b2b second result", dif.result, 32'd2);

    // reset 10 cycles after accept aborts with no done pulse
    @(posedge clk); #1;
    issue(32'd12345, 32'd1, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort busy", {31'b0, dif.busy}, 32'd0);
    chk("abort done", {31'b0, dif.done}, 32'd0);
    chk("abort q", dif.q, 32'd0);
    chk("abort r", dif.r, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dif.done || dif.busy) bcnt++;
    end
    chk("abort no done", bcnt, 0);
    issue(32'd1000, 32'd10, 1'b0, 1'b0);
    wait_done("post reset", 32'd0, lat, bcnt);
    chk("post reset latency", lat, 33);
    chk("post reset q", dif.q, 32'd100);
    chk("post reset r", dif.r, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
